// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus: EX instruction, comparator flags,
// redirect handshake toward fetch, squash/exception outputs and perf counters.
interface branch_resolve_if #(
   parameter int CNT_W = 32
);
   logic             ex_valid;
   logic             ex_ready;
   logic             ex_is_branch;
   logic             ex_is_jal;
   logic             ex_is_jalr;
   logic [2:0]       ex_funct3;
   logic [31:0]      ex_pc;
   logic [31:0]      ex_imm;
   logic [31:0]      ex_rs1;
   logic             ex_pred_taken;
   logic             BrUn;
   logic             BrEq;
   logic             BrLT;
   logic             redirect_valid;
   logic             redirect_ready;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic             misalign_exc;
   logic             illegal_exc;
   logic [CNT_W-1:0] perf_branches;
   logic [CNT_W-1:0] perf_mispredicts;

   // pipeline / fetch side
   modport master (
      output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_imm, ex_rs1, ex_pred_taken, BrEq, BrLT, redirect_ready,
      input  ex_ready, BrUn, redirect_valid, redirect_pc, flush,
             misalign_exc, illegal_exc, perf_branches, perf_mispredicts
   );

   // resolution unit side
   modport slave (
      input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_imm, ex_rs1, ex_pred_taken, BrEq, BrLT, redirect_ready,
      output ex_ready, BrUn, redirect_valid, redirect_pc, flush,
             misalign_exc, illegal_exc, perf_branches, perf_mispredicts
   );
endinterface

// File: rtl/branch_resolve.sv
// RV32I execute-stage branch resolution: outcome decode, mispredict redirect, squash timer.
// Optional performance counters enabled by defining BRANCH_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting EX control transfers
// REDIRECT | corrected PC offered to fetch, younger instructions flushed
// SQUASH   | flush held while the squash down-counter runs out
module branch_resolve #(
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W         = 32
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SQUASH   = 2'd2
   } stateT;

   stateT       state;
   stateT       nextState;
   logic [3:0]  squashCnt;
   logic [31:0] redirectPc;
   logic        misalignQ;
   logic        illegalQ;

   logic        isCtrl;
   logic        taken;
   logic        illegal;
   logic [31:0] target;
   logic [31:0] fallThru;
   logic [31:0] correctPc;
   logic        misalign;
   logic        mispredict;
   logic        accept;
   logic        doRedirect;

   logic        exReady;
   logic        redirValid;
   logic        flushC;
   logic        loadCnt;
   logic        decCnt;

   assign bus.BrUn = bus.ex_funct3[1];

   assign isCtrl  = bus.ex_is_branch | bus.ex_is_jal | bus.ex_is_jalr;
   assign illegal = bus.ex_is_branch & (bus.ex_funct3[2:1] == 2'b01);

   always_comb begin
      taken = 1'b0;
      if (bus.ex_is_jal || bus.ex_is_jalr) begin
         taken = 1'b1;
      end else if (bus.ex_is_branch) begin
         case (bus.ex_funct3)
            3'b000:         taken = bus.BrEq;
            3'b001:         taken = ~bus.BrEq;
            3'b100, 3'b110: taken = bus.BrLT;
            3'b101, 3'b111: taken = ~bus.BrLT;
            default:        taken = 1'b0;
         endcase
      end
   end

   assign target     = bus.ex_is_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE)
                                      : (bus.ex_pc + bus.ex_imm);
   assign fallThru   = bus.ex_pc + 32'd4;
   assign correctPc  = taken ? target : fallThru;
   assign misalign   = taken & target[1];
   assign mispredict = taken ^ bus.ex_pred_taken;
   // a misaligned taken target is left to the trap path, never redirected
   assign doRedirect = mispredict & ~misalign;
   assign accept     = bus.ex_valid & (state == IDLE) & isCtrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState  = state;
      exReady    = 1'b0;
      redirValid = 1'b0;
      flushC     = 1'b0;
      loadCnt    = 1'b0;
      decCnt     = 1'b0;
      case (state)
         IDLE: begin
            exReady = 1'b1;
            if (accept && doRedirect) nextState = REDIRECT;
         end
         REDIRECT: begin
            redirValid = 1'b1;
            flushC     = 1'b1;
            if (bus.redirect_ready) begin
               nextState = SQUASH;
               loadCnt   = 1'b1;
            end
         end
         SQUASH: begin
            flushC = 1'b1;
            decCnt = 1'b1;
            if (squashCnt == 4'd1) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         squashCnt  <= 4'd0;
         redirectPc <= 32'd0;
         misalignQ  <= 1'b0;
         illegalQ   <= 1'b0;
      end else begin
         if (loadCnt)     squashCnt <= 4'(SQUASH_CYCLES);
         else if (decCnt) squashCnt <= squashCnt - 4'd1;
         if (accept && doRedirect) redirectPc <= correctPc;
         misalignQ <= accept & misalign;
         illegalQ  <= accept & illegal;
      end
   end

   assign bus.ex_ready       = exReady;
   assign bus.redirect_valid = redirValid;
   assign bus.redirect_pc    = redirectPc;
   assign bus.flush          = flushC;
   assign bus.misalign_exc   = misalignQ;
   assign bus.illegal_exc    = illegalQ;

`ifdef BRANCH_PERF_EN
   logic [CNT_W-1:0] perfBranches;
   logic [CNT_W-1:0] perfMispredicts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfBranches    <= '0;
         perfMispredicts <= '0;
      end else begin
         if (accept)               perfBranches    <= perfBranches + 1'b1;
         if (accept && doRedirect) perfMispredicts <= perfMispredicts + 1'b1;
      end
   end

   assign bus.perf_branches    = perfBranches;
   assign bus.perf_mispredicts = perfMispredicts;
`else
   assign bus.perf_branches    = {CNT_W{1'b0}};
   assign bus.perf_mispredicts = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (SQUASH_CYCLES = 2).
module tb_branch_resolve;

`ifdef BRANCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   nChecks = 0;
   int   nPass   = 0;

   branch_resolve_if #(.CNT_W(32)) bus ();

   branch_resolve #(.SQUASH_CYCLES(2), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setEx(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic pred, input logic eq, input logic lt);
      bus.ex_valid      = 1'b1;
      bus.ex_is_branch  = br;
      bus.ex_is_jal     = jal;
      bus.ex_is_jalr    = jalr;
      bus.ex_funct3     = f3;
      bus.ex_pc         = pc;
      bus.ex_imm        = imm;
      bus.ex_rs1        = rs1;
      bus.ex_pred_taken = pred;
      bus.BrEq          = eq;
      bus.BrLT          = lt;
   endtask

   task automatic clearEx();
      bus.ex_valid     = 1'b0;
      bus.ex_is_branch = 1'b0;
      bus.ex_is_jal    = 1'b0;
      bus.ex_is_jalr   = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clearEx();
      bus.ex_funct3      = 3'b000;
      bus.ex_pc          = 32'd0;
      bus.ex_imm         = 32'd0;
      bus.ex_rs1         = 32'd0;
      bus.ex_pred_taken  = 1'b0;
      bus.BrEq           = 1'b0;
      bus.BrLT           = 1'b0;
      bus.redirect_ready = 1'b0;
      #2 rst = 1'b1;
      step();
      step();
      checkVal("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
      checkVal("rst_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("rst_rpc", bus.redirect_pc, 32'd0);
      checkVal("rst_flush", 32'(bus.flush), 32'd0);
      checkVal("rst_misalign", 32'(bus.misalign_exc), 32'd0);
      checkVal("rst_illegal", 32'(bus.illegal_exc), 32'd0);
      checkVal("rst_perf_br", bus.perf_branches, 32'd0);
      checkVal("rst_perf_mp", bus.perf_mispredicts, 32'd0);
      rst = 1'b0;
      step();

      // BEQ taken, predicted not taken; fetch ready immediately
      bus.redirect_ready = 1'b1;
      setEx(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 0, 1, 0);
      #1 checkVal("beq_brun", 32'(bus.BrUn), 32'd0);
      step();
      clearEx();
      checkVal("beq_rvalid", 32'(bus.redirect_valid), 32'd1);
      checkVal("beq_rpc", bus.redirect_pc, 32'h120);
      checkVal("beq_flush", 32'(bus.flush), 32'd1);
      checkVal("beq_ex_ready", 32'(bus.ex_ready), 32'd0);
      step();
      checkVal("beq_sq1_flush", 32'(bus.flush), 32'd1);
      checkVal("beq_sq1_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("beq_sq1_ready", 32'(bus.ex_ready), 32'd0);
      step();
      checkVal("beq_sq2_flush", 32'(bus.flush), 32'd1);
      checkVal("beq_sq2_ready", 32'(bus.ex_ready), 32'd0);
      step();
      checkVal("beq_idle_flush", 32'(bus.flush), 32'd0);
      checkVal("beq_idle_ready", 32'(bus.ex_ready), 32'd1);

      // BLTU not taken, correctly predicted; redirect_ready high in IDLE is ignored
      setEx(1, 0, 0, 3'b110, 32'h300, 32'h40, 32'h0, 0, 0, 0);
      #1 checkVal("bltu_brun", 32'(bus.BrUn), 32'd1);
      step();
      clearEx();
      checkVal("bltu_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("bltu_flush", 32'(bus.flush), 32'd0);
      checkVal("bltu_ready", 32'(bus.ex_ready), 32'd1);

      // JALR to a misaligned target: exception pulse only
      setEx(0, 0, 1, 3'b000, 32'h500, 32'h0, 32'h2003, 0, 0, 0);
      step();
      clearEx();
      checkVal("jalr_mis_exc", 32'(bus.misalign_exc), 32'd1);
      checkVal("jalr_mis_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("jalr_mis_flush", 32'(bus.flush), 32'd0);
      step();
      checkVal("jalr_mis_pulse", 32'(bus.misalign_exc), 32'd0);

      // illegal funct3 010
      setEx(1, 0, 0, 3'b010, 32'h600, 32'h8, 32'h0, 0, 1, 1);
      step();
      clearEx();
      checkVal("ill_exc", 32'(bus.illegal_exc), 32'd1);
      checkVal("ill_rvalid", 32'(bus.redirect_valid), 32'd0);
      step();
      checkVal("ill_pulse", 32'(bus.illegal_exc), 32'd0);

      // no class bit set: ignored even with a "wrong" prediction
      setEx(0, 0, 0, 3'b000, 32'h700, 32'h8, 32'h0, 1, 0, 0);
      step();
      clearEx();
      checkVal("none_rvalid", 32'(bus.redirect_valid), 32'd0);

      // BNE not taken but predicted taken -> fallthrough; fetch stalls 5 cycles
      bus.redirect_ready = 1'b0;
      setEx(1, 0, 0, 3'b001, 32'h400, 32'h40, 32'h0, 1, 1, 0);
      step();
      setEx(1, 0, 0, 3'b000, 32'h900, 32'h10, 32'h0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         checkVal("stall_rvalid", 32'(bus.redirect_valid), 32'd1);
         checkVal("stall_rpc", bus.redirect_pc, 32'h404);
         checkVal("stall_flush", 32'(bus.flush), 32'd1);
         checkVal("stall_ready", 32'(bus.ex_ready), 32'd0);
         bus.ex_pc = bus.ex_pc + 32'h100;
         if (i == 4) bus.redirect_ready = 1'b1;
         step();
      end
      clearEx();
      checkVal("stall_sq_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("stall_sq_flush", 32'(bus.flush), 32'd1);
      step();
      step();
      checkVal("stall_idle_ready", 32'(bus.ex_ready), 32'd1);

      // JAL and BGE taken, both correctly predicted
      setEx(0, 1, 0, 3'b000, 32'h1000, 32'h10, 32'h0, 1, 0, 0);
      step();
      setEx(1, 0, 0, 3'b101, 32'h200, 32'h8, 32'h0, 1, 0, 0);
      checkVal("jal_rvalid", 32'(bus.redirect_valid), 32'd0);
      step();
      clearEx();
      checkVal("bge_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("bge_ready", 32'(bus.ex_ready), 32'd1);

      // JALR target wraps past 2^32 and has bit 0 cleared
      setEx(0, 0, 1, 3'b000, 32'h800, 32'h15, 32'hFFFF_FFF0, 0, 0, 0);
      step();
      clearEx();
      checkVal("jalr_wrap_rvalid", 32'(bus.redirect_valid), 32'd1);
      checkVal("jalr_wrap_rpc", bus.redirect_pc, 32'h4);
      checkVal("jalr_wrap_misal", 32'(bus.misalign_exc), 32'd0);
      step();
      step();
      step();
      checkVal("jalr_wrap_idle", 32'(bus.ex_ready), 32'd1);

      // 8 accepted transfers so far, 3 of them redirected
      checkVal("perf_branches", bus.perf_branches, PERF ? 32'd8 : 32'd0);
      checkVal("perf_mispredicts", bus.perf_mispredicts, PERF ? 32'd3 : 32'd0);

      // reset while a redirect is pending
      bus.redirect_ready = 1'b0;
      setEx(1, 0, 0, 3'b000, 32'hA00, 32'h20, 32'h0, 0, 1, 0);
      step();
      clearEx();
      checkVal("rstmid_rvalid_pre", 32'(bus.redirect_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkVal("rstmid_rvalid", 32'(bus.redirect_valid), 32'd0);
      checkVal("rstmid_flush", 32'(bus.flush), 32'd0);
      checkVal("rstmid_perf", bus.perf_branches, 32'd0);
      rst = 1'b0;
      step();
      checkVal("rstmid_ready", 32'(bus.ex_ready), 32'd1);
      checkVal("rstmid_rvalid_post", 32'(bus.redirect_valid), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the RV32I pipeline; it is the consumer of the branch comparator's BrEq/BrLT flags. It drives the comparator's BrUn select from funct3, decodes the taken/not-taken outcome for BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, and checks the outcome against the fetch-stage prediction. On a mispredict it registers a PC redirect toward fetch with a valid/ready handshake and squashes younger instructions for a fixed number of cycles.

## Interface
Parameters:
- SQUASH_CYCLES, 2: cycles `flush` stays high after the redirect is accepted (1..15).
- CNT_W, 32: width of the performance counters (only used with BRANCH_PERF_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX holds a valid control-transfer instruction.
- ex_ready  out  1  unit accepts the EX instruction. Transfer happens when ex_valid & ex_ready.
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  instruction class, one-hot. All zero means not a control transfer and is ignored.
- ex_funct3  in  3  branch condition code.
- ex_pc  in  32  instruction PC.
- ex_imm  in  32  sign-extended immediate.
- ex_rs1  in  32  rs1 value, used for JALR.
- ex_pred_taken  in  1  fetch-stage prediction.
- BrUn  out  1  comparator unsigned select = ex_funct3[1]. Combinational, not reset.
- BrEq, BrLT  in  1 each  comparator flags for the current EX operands.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  32  corrected fetch PC.
- flush  out  1  squash the IF/ID and ID/EX registers.
- misalign_exc  out  1  one-cycle pulse: a taken target is not 4-byte aligned.
- illegal_exc  out  1  one-cycle pulse: a branch with funct3 010 or 011.
- perf_branches, perf_mispredicts  out  CNT_W each  performance counters.

## Operation
- Taken decode (branch only):
  - 000: BrEq
  - 001: !BrEq
  - 100 and 110: BrLT
  - 101 and 111: !BrLT
  - 010 and 011: not taken, illegal_exc.
- JAL and JALR are always taken.
- Target computation, 32-bit wrap-around with no overflow detection:
  - branch/JAL: ex_pc + ex_imm
  - JALR: (ex_rs1 + ex_imm) & ~1
  - fallthrough: ex_pc + 4
- Mispredict = taken != ex_pred_taken. Corrected PC = taken ? target : fallthrough.
- Taken with target[1] = 1: pulse misalign_exc, no redirect, no flush. The trap path owns recovery.
- FSM states:
  - IDLE: ex_ready = 1. An accepted mispredict goes to REDIRECT. Anything else stays in IDLE.
  - REDIRECT: redirect_valid = 1, redirect_pc held stable, flush = 1, ex_ready = 0. Stays until redirect_ready, then goes to SQUASH and loads the counter with SQUASH_CYCLES.
  - SQUASH: flush = 1, ex_ready = 0. The counter decrements each cycle; at 1 the FSM returns to IDLE.
- Simultaneous events:
  - redirect_ready high in the first REDIRECT cycle: the handshake completes that edge.
  - redirect_ready high while in IDLE: ignored.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any pending redirect is dropped.

## Timing
- The decision is registered on the edge where ex_valid & ex_ready. redirect_valid, flush, and the exception pulses assert the following cycle (latency 1).
- Minimum mispredict penalty is 1 + SQUASH_CYCLES cycles with ex_ready low.
- Reset values:
  - state IDLE, ex_ready = 1
  - redirect_valid = 0, redirect_pc = 0, flush = 0
  - misalign_exc = 0, illegal_exc = 0
  - perf counters = 0
- Perf counters wrap modulo 2^CNT_W.

## Configuration
- BRANCH_PERF_EN defined:
  - perf_branches increments on every accepted control transfer.
  - perf_mispredicts increments on every accepted mispredict that triggers a redirect.
- BRANCH_PERF_EN undefined: no counter registers exist and both perf outputs are constant 0.

## Test plan
- BEQ with pc = 0x100, imm = 0x20, BrEq = 1, pred = 0 -> next cycle redirect_valid = 1, redirect_pc = 0x120, flush = 1. With redirect_ready = 1, flush stays high for 2 more cycles, then ex_ready = 1.
- BLTU with funct3 = 110 -> BrUn = 1. BrLT = 0, pred = 0 -> no redirect, flush = 0, ex_ready stays 1.
- JALR with rs1 = 0x2003, imm = 0 -> target 0x2002 -> misalign_exc pulses for 1 cycle, redirect_valid = 0.
- Mispredict with redirect_ready held low for 5 cycles -> redirect_valid and redirect_pc stay stable for all 5 cycles, then the handshake completes.
- rst asserted while in REDIRECT -> redirect_valid = 0 and flush = 0 immediately; ex_ready = 1 after release.
- With BRANCH_PERF_EN: 3 branches including 1 mispredict -> perf_branches = 3, perf_mispredicts = 1. Without the macro, both outputs read 0.
